bitrev_dma_manager: RTL and testbench
=====================================

# bitrev_dma_manager

OBI manager that feeds a memory buffer through the bit-reversal peripheral and writes the result back to memory, so the CPU does not move the samples itself. It sits on a Croc manager port. It reads N words from a source buffer and pushes each one into the peripheral INPUT register (base+0x0). It then pops N words from the peripheral OUTPUT register (base+0x4) and writes them to a destination buffer. Only one bus transaction is outstanding at a time.

## Interface
Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig: manager port configuration.
- LenW, 16: width of the word-count input.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- start_i, in, 1: start pulse; sampled only in IDLE.
- src_addr_i, in, 32: source buffer base; word aligned, bits [1:0] ignored.
- dst_addr_i, in, 32: destination buffer base; word aligned.
- periph_base_i, in, 32: bit-reversal peripheral base address.
- len_i, in, LenW: number of words N.
- busy_o, out, 1: high from start until done.
- done_o, out, 1: one-cycle pulse at the end of a job or an abort.
- err_o, out, 1: sticky bus-error flag; cleared by the next accepted start.
- obi_req_o, out, mgr_obi_req_t: manager request.
- obi_rsp_i, in, mgr_obi_rsp_t: manager response.

## Operation
- States:
  - IDLE
  - SRC_RD
  - SRC_RSP
  - IN_WR
  - [POLL_RD, POLL_RSP]
  - OUT_RD
  - OUT_RSP
  - DST_WR
  - DST_RSP
  - FIN
- Accepting a job:
  - start_i in IDLE latches src, dst, base and len.
  - It clears the index counter, clears err_o and sets busy_o.
  - start_i outside IDLE is ignored.
- len_i = 0: IDLE goes to FIN, with no bus traffic.
- Push phase, for index i = 0..N-1:
  - SRC_RD: read src + 4i.
  - SRC_RSP: wait for rvalid and capture rdata.
  - IN_WR: write the captured word to base+0x0 with be = 4'hF.
  - IN_WR completes at gnt; no rvalid is awaited, because the peripheral issues no write response.
  - Then i++. When i = N, clear i and go to the pop phase.
- Pop phase, for i = 0..N-1:
  - OUT_RD: read base+0x4. The peripheral stalls rvalid until data is available.
  - OUT_RSP: capture rdata.
  - DST_WR: write the word to dst + 4i with be = 4'hF.
  - DST_RSP: wait for rvalid. Then i++, and at i = N go to FIN.
- FIN: pulse done_o, clear busy_o, go to IDLE.
- Request rules:
  - req is held high with a, we, wdata and be stable until gnt.
  - aid is always 0 and a_optional is 0.
  - The next req is not raised until the current transaction completes.
- Addressing: byte address = base + {i, 2'b00}, 32-bit wraparound, no bounds check.
- Error handling:
  - rvalid with r.err = 1 in any RSP state sets err_o and goes to FIN.
  - The index counter is not advanced.
  - Data already written stays written.
- N larger than the peripheral frame size is the software's responsibility. The push phase then stalls on gnt until the core drains, and the pop phase is never reached. That is a deadlock: do not program it.

## Timing
- Reset values:
  - state = IDLE
  - busy_o = 0
  - done_o = 0
  - err_o = 0
  - obi_req_o.req = 0
  - all request fields = 0
- busy_o rises the cycle after start_i is sampled.
- The first req rises in the same cycle as busy_o.
- Each read or memory write:
  - The request cycle lasts until gnt.
  - rvalid is accepted no earlier than the cycle after gnt.
  - The next request is issued the cycle after rvalid.
- IN_WR: the next request is issued the cycle after gnt.
- Best case with zero-wait slaves:
  - push = 3 cycles/word
  - pop = 4 cycles/word
  - total = 7N + 2 cycles, start to done_o.
- len_i = 0: done_o is high 2 cycles after start.
- Reset mid-job: the block returns immediately to reset values. The bus request is dropped and any pending rvalid is not tracked.

## Configuration
- BITREV_DMA_STATUS_POLL_EN
  - Defined: before every OUT_RD, POLL_RD reads base+0x8, and POLL_RSP checks rdata[0].
    - If rdata[0] = 0, return to POLL_RD.
    - If rdata[0] = 1, go to OUT_RD.
    - The bus is never held by a blocking OUTPUT read.
    - Each poll costs 2 cycles or more.
  - Undefined: the POLL states are absent and OUT_RD is issued directly.

## Test plan
- Basic job: N=4, src words 0x11,0x22,0x33,0x44, zero-wait memory, model peripheral → 4 IN writes at base+0x0 in order, 4 OUT reads, dst holds the model output, done_o pulse at cycle 30, err_o = 0.
- Zero length: len_i = 0 → done_o pulses 2 cycles after start, no req ever asserted, busy_o high for exactly 1 cycle.
- gnt backpressure: randomised gnt stalls of 0-5 cycles → addr/wdata stable while req && !gnt, still only one transaction outstanding, same final dst contents.
- Error abort: src read at index 2 returns err = 1 → err_o = 1, done_o pulse, no further req, dst untouched; the next start clears err_o.
- Reset mid-job: assert rst_ni low during DST_WR of word 1 → all outputs 0 in the same cycle; a new job afterwards completes correctly.
- With BITREV_DMA_STATUS_POLL_EN: STATUS returns 0 three times, then 1 → 4 STATUS reads precede each OUTPUT read; without the macro, no read of base+0x8 occurs.

Source files
------------

// File: rtl/bitrev_dma_manager.sv
// OBI manager that streams a memory buffer through the bit-reversal peripheral and back.
// Optional STATUS polling before every OUTPUT read: define BITREV_DMA_STATUS_POLL_EN.

package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32'd32, DataWidth: 32'd32, IdWidth: 32'd1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic [0:0]  a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic [0:0]  r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;

endpackage

module bitrev_dma_manager #(
  parameter obi_pkg::obi_cfg_t ObiCfg        = obi_pkg::ObiDefaultConfig,
  parameter int unsigned       LenW          = 16,
  parameter type               mgr_obi_req_t = obi_pkg::obi_req_t,
  parameter type               mgr_obi_rsp_t = obi_pkg::obi_rsp_t
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [31:0]     src_addr_i,
  input  logic [31:0]     dst_addr_i,
  input  logic [31:0]     periph_base_i,
  input  logic [LenW-1:0] len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output mgr_obi_req_t    obi_req_o,
  input  mgr_obi_rsp_t    obi_rsp_i
);

  localparam int unsigned AW = ObiCfg.AddrWidth;
  localparam int unsigned DW = ObiCfg.DataWidth;

  localparam logic [AW-1:0] InOff   = AW'(32'h0);
  localparam logic [AW-1:0] OutOff  = AW'(32'h4);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SRC_RD   = 4'd1,
    SRC_RSP  = 4'd2,
    IN_WR    = 4'd3,
    OUT_RD   = 4'd4,
    OUT_RSP  = 4'd5,
    DST_WR   = 4'd6,
    DST_RSP  = 4'd7,
    FIN      = 4'd8
`ifdef BITREV_DMA_STATUS_POLL_EN
    ,
    POLL_RD  = 4'd9,
    POLL_RSP = 4'd10
`endif
  } state_e;

`ifdef BITREV_DMA_STATUS_POLL_EN
  localparam state_e        PopEntry = POLL_RD;
  localparam logic [AW-1:0] PopOff   = AW'(32'h8);
  localparam logic [AW-1:0] StatOff  = AW'(32'h8);
`else
  localparam state_e        PopEntry = OUT_RD;
  localparam logic [AW-1:0] PopOff   = OutOff;
`endif

  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base, input logic [LenW-1:0] idx);
    return base + AW'({idx, 2'b00});
  endfunction

  state_e          state_q, state_d;
  logic [LenW-1:0] idx_q, idx_d, len_q, len_d;
  logic [AW-1:0]   src_q, src_d, dst_q, dst_d, base_q, base_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            req_q, req_d, we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            gnt_s, rvalid_s, rerr_s;
  logic [DW-1:0]   rdata_s;
  logic [LenW-1:0] idx_inc_s;
  logic            issue_s, issue_we_s;
  logic [AW-1:0]   issue_addr_s;
  logic [DW-1:0]   issue_wdata_s;
  logic            unused_s;

  assign gnt_s     = obi_rsp_i.gnt & req_q;
  assign rvalid_s  = obi_rsp_i.rvalid;
  assign rerr_s    = obi_rsp_i.r.err;
  assign rdata_s   = obi_rsp_i.r.rdata;
  assign idx_inc_s = idx_q + LenW'(1'b1);
  assign unused_s  = ^{src_addr_i[1:0], dst_addr_i[1:0], periph_base_i[1:0],
                       obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

  // Next-state, job bookkeeping and the request to raise after this cycle.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    src_d         = src_q;
    dst_d         = dst_q;
    base_d        = base_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    req_d         = req_q;
    we_d          = we_q;
    be_d          = be_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    issue_s       = 1'b0;
    issue_we_s    = 1'b0;
    issue_addr_s  = '0;
    issue_wdata_s = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d  = {src_addr_i[AW-1:2], 2'b00};
          dst_d  = {dst_addr_i[AW-1:2], 2'b00};
          base_d = {periph_base_i[AW-1:2], 2'b00};
          len_d  = len_i;
          idx_d  = '0;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (len_i == '0) begin
            state_d = FIN;
          end else begin
            state_d      = SRC_RD;
            issue_s      = 1'b1;
            issue_addr_s = {src_addr_i[AW-1:2], 2'b00};
          end
        end else begin
          state_d = IDLE;
        end
      end
      SRC_RD: begin
        if (gnt_s) state_d = SRC_RSP;
        else       state_d = SRC_RD;
      end
      SRC_RSP: begin
        if (rvalid_s && rerr_s) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (rvalid_s) begin
          state_d       = IN_WR;
          issue_s       = 1'b1;
          issue_we_s    = 1'b1;
          issue_addr_s  = base_q + InOff;
          issue_wdata_s = rdata_s;
        end else begin
          state_d = SRC_RSP;
        end
      end
      // The peripheral gives no write response, so the grant ends the write.
      IN_WR: begin
        if (gnt_s && (idx_inc_s == len_q)) begin
          idx_d        = '0;
          state_d      = PopEntry;
          issue_s      = 1'b1;
          issue_addr_s = base_q + PopOff;
        end else if (gnt_s) begin
          idx_d        = idx_inc_s;
          state_d      = SRC_RD;
          issue_s      = 1'b1;
          issue_addr_s = word_addr(src_q, idx_inc_s);
        end else begin
          state_d = IN_WR;
        end
      end
`ifdef BITREV_DMA_STATUS_POLL_EN
      POLL_RD: begin
        if (gnt_s) state_d = POLL_RSP;
        else       state_d = POLL_RD;
      end
      POLL_RSP: begin
        if (rvalid_s && rerr_s) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (rvalid_s && rdata_s[0]) begin
          state_d      = OUT_RD;
          issue_s      = 1'b1;
          issue_addr_s = base_q + OutOff;
        end else if (rvalid_s) begin
          state_d      = POLL_RD;
          issue_s      = 1'b1;
          issue_addr_s = base_q + StatOff;
        end else begin
          state_d = POLL_RSP;
        end
      end
`endif
      OUT_RD: begin
        if (gnt_s) state_d = OUT_RSP;
        else       state_d = OUT_RD;
      end
      OUT_RSP: begin
        if (rvalid_s && rerr_s) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (rvalid_s) begin
          state_d       = DST_WR;
          issue_s       = 1'b1;
          issue_we_s    = 1'b1;
          issue_addr_s  = word_addr(dst_q, idx_q);
          issue_wdata_s = rdata_s;
        end else begin
          state_d = OUT_RSP;
        end
      end
      DST_WR: begin
        if (gnt_s) state_d = DST_RSP;
        else       state_d = DST_WR;
      end
      DST_RSP: begin
        if (rvalid_s && rerr_s) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (rvalid_s && (idx_inc_s == len_q)) begin
          idx_d   = '0;
          state_d = FIN;
        end else if (rvalid_s) begin
          idx_d        = idx_inc_s;
          state_d      = PopEntry;
          issue_s      = 1'b1;
          issue_addr_s = base_q + PopOff;
        end else begin
          state_d = DST_RSP;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A granted request drops its fields; a new issue in the same cycle wins.
    if (issue_s) begin
      req_d   = 1'b1;
      we_d    = issue_we_s;
      be_d    = 4'hF;
      addr_d  = issue_addr_s;
      wdata_d = issue_wdata_s;
    end else if (gnt_s) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      be_d    = 4'h0;
      addr_d  = '0;
      wdata_d = '0;
    end else begin
      req_d = req_q;
    end
  end

  // State and request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

  // Pack the registered request; aid and a_optional stay zero.
  always_comb begin
    obi_req_o         = '0;
    obi_req_o.req     = req_q;
    obi_req_o.a.addr  = addr_q;
    obi_req_o.a.we    = we_q;
    obi_req_o.a.be    = be_q;
    obi_req_o.a.wdata = wdata_q;
  end

endmodule

// File: tb/tb_bitrev_dma_manager.sv
// Directed bench for bitrev_dma_manager with a zero-wait memory, a bit-reversal
// peripheral model and optional grant stalls.

module tb_bitrev_dma_manager;

  localparam logic [31:0] SRC = 32'h0000_0100;
  localparam logic [31:0] DST = 32'h0000_0200;
  localparam logic [31:0] PB  = 32'h2000_0000;

  logic        clk_i, rst_ni, start_i;
  logic [31:0] src_addr, dst_addr, pbase;
  logic [15:0] len;
  logic        busy, done, err;
  obi_pkg::obi_req_t req_s;
  obi_pkg::obi_rsp_t rsp_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] fifo [$];
  logic [31:0] in_log [$];
  int n_gnt = 0, n_in_wr = 0, n_out_rd = 0, n_stat_rd = 0;
  logic        stall_en;
  logic [31:0] err_addr;
  logic [2:0]  stall_q;
  logic [1:0]  stat_cnt_q;
  logic        rvalid_q, rerr_q, hold_q, gnt_s;
  logic [31:0] rdata_q;
  obi_pkg::obi_a_chan_t hold_a_q;

  bitrev_dma_manager dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .src_addr_i   (src_addr),
    .dst_addr_i   (dst_addr),
    .periph_base_i(pbase),
    .len_i        (len),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .obi_req_o    (req_s),
    .obi_rsp_i    (rsp_s)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  assign gnt_s = req_s.req && (stall_q == 3'd0);
  always_comb begin
    rsp_s         = '0;
    rsp_s.gnt     = gnt_s;
    rsp_s.rvalid  = rvalid_q;
    rsp_s.r.rdata = rdata_q;
    rsp_s.r.err   = rerr_q;
  end

  // Memory + peripheral responder.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q   <= 1'b0;
      rerr_q     <= 1'b0;
      rdata_q    <= 32'h0;
      stall_q    <= 3'd0;
      stat_cnt_q <= 2'd0;
      hold_q     <= 1'b0;
      hold_a_q   <= '0;
      fifo.delete();
    end else begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= 32'h0;
      hold_q   <= req_s.req && !gnt_s;
      hold_a_q <= req_s.a;
      if (gnt_s) begin
        n_gnt   <= n_gnt + 1;
        stall_q <= stall_en ? 3'($urandom_range(5, 0)) : 3'd0;
        if (req_s.a.addr == PB && req_s.a.we) begin
          fifo.push_back(req_s.a.wdata);
          in_log.push_back(req_s.a.wdata);
          n_in_wr <= n_in_wr + 1;
        end else if (req_s.a.addr == PB + 32'h4 && !req_s.a.we) begin
          n_out_rd <= n_out_rd + 1;
          rvalid_q <= 1'b1;
          if (fifo.size() > 0) rdata_q <= rev32(fifo.pop_front());
          else                 rdata_q <= 32'hDEAD_BEEF;
        end else if (req_s.a.addr == PB + 32'h8 && !req_s.a.we) begin
          n_stat_rd <= n_stat_rd + 1;
          rvalid_q  <= 1'b1;
          if (stat_cnt_q == 2'd3) begin
            rdata_q    <= 32'h1;
            stat_cnt_q <= 2'd0;
          end else begin
            rdata_q    <= 32'h0;
            stat_cnt_q <= stat_cnt_q + 2'd1;
          end
        end else begin
          rvalid_q <= 1'b1;
          rerr_q   <= (req_s.a.addr == err_addr) && !req_s.a.we;
          if (req_s.a.we) mem[req_s.a.addr[11:2]] <= req_s.a.wdata;
          else            rdata_q <= mem[req_s.a.addr[11:2]];
        end
      end else if (req_s.req && stall_q != 3'd0) begin
        stall_q <= stall_q - 3'd1;
      end
    end
  end

  // Protocol monitor: stable request until grant, single outstanding transaction.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rvalid_q) chk("one_outstanding", {31'h0, req_s.req}, 32'h0);
      if (hold_q) begin
        chk("hold_req", {31'h0, req_s.req}, 32'h1);
        chk("hold_addr", req_s.a.addr, hold_a_q.addr);
        chk("hold_wdata", req_s.a.wdata, hold_a_q.wdata);
      end
      if (req_s.req) begin
        chk("aid_opt_be", {26'h0, req_s.a.aid, req_s.a.a_optional, req_s.a.be}, 32'hF);
      end
    end
  end

  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk_i);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start_i  = 1'b1;
    t0       = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int k = 0; k < limit; k++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk_i);
    end
    chk("done_seen", {31'h0, lat != -1}, 32'h1);
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    mem[a[11:2]]         = w0;
    mem[a[11:2] + 10'd1] = w1;
    mem[a[11:2] + 10'd2] = w2;
    mem[a[11:2] + 10'd3] = w3;
  endtask

  initial begin
    int lat, g0, i0, o0, s0;
    rst_ni   = 1'b1;
    start_i  = 1'b0;
    src_addr = 32'h0;
    dst_addr = 32'h0;
    pbase    = PB;
    len      = 16'h0;
    stall_en = 1'b0;
    err_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    #3 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset state
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_req", {31'h0, req_s.req}, 32'h0);
    chk("rst_addr", req_s.a.addr, 32'h0);
    chk("rst_wdata", req_s.a.wdata, 32'h0);
    chk("rst_be_we", {27'h0, req_s.a.we, req_s.a.be}, 32'h0);
    rst_ni = 1'b1;

    // Basic job N=4
    fill(SRC, 32'h11, 32'h22, 32'h33, 32'h44);
    fill(DST, 32'h0, 32'h0, 32'h0, 32'h0);
    i0 = in_log.size(); o0 = n_out_rd; s0 = n_stat_rd;
    start_job(SRC, DST, 16'd4);
    chk("basic_busy_c1", {31'h0, busy}, 32'h1);
    chk("basic_req_c1", {31'h0, req_s.req}, 32'h1);
    chk("basic_addr_c1", req_s.a.addr, SRC);
    wait_done(200, lat);
`ifndef BITREV_DMA_STATUS_POLL_EN
    chk("basic_latency", lat, 32'd30);
`endif
    chk("basic_busy_end", {31'h0, busy}, 32'h0);
    chk("basic_err", {31'h0, err}, 32'h0);
    chk("basic_in_cnt", in_log.size() - i0, 32'd4);
    chk("basic_in0", in_log[i0], 32'h11);
    chk("basic_in3", in_log[i0+3], 32'h44);
    chk("basic_out_cnt", n_out_rd - o0, 32'd4);
`ifdef BITREV_DMA_STATUS_POLL_EN
    chk("basic_status_reads", n_stat_rd - s0, 32'd16);
`else
    chk("basic_status_reads", n_stat_rd - s0, 32'd0);
`endif
    chk("basic_dst0", mem[DST[11:2]], 32'h8800_0000);
    chk("basic_dst1", mem[DST[11:2] + 10'd1], 32'h4400_0000);
    chk("basic_dst2", mem[DST[11:2] + 10'd2], 32'hCC00_0000);
    chk("basic_dst3", mem[DST[11:2] + 10'd3], 32'h2200_0000);
    @(negedge clk_i);
    chk("basic_done_pulse", {31'h0, done}, 32'h0);

    // Zero length
    g0 = n_gnt;
    start_job(SRC, DST, 16'd0);
    chk("zero_busy_c1", {31'h0, busy}, 32'h1);
    chk("zero_req_c1", {31'h0, req_s.req}, 32'h0);
    @(negedge clk_i);
    chk("zero_done_c2", {31'h0, done}, 32'h1);
    chk("zero_busy_c2", {31'h0, busy}, 32'h0);
    chk("zero_no_traffic", n_gnt - g0, 32'd0);

    // Grant backpressure, unaligned source base
    stall_en = 1'b1;
    fill(DST, 32'h0, 32'h0, 32'h0, 32'h0);
    start_job(SRC + 32'h3, DST, 16'd4);
    chk("bp_addr_c1", req_s.a.addr, SRC);
    wait_done(600, lat);
    chk("bp_err", {31'h0, err}, 32'h0);
    chk("bp_dst0", mem[DST[11:2]], 32'h8800_0000);
    chk("bp_dst3", mem[DST[11:2] + 10'd3], 32'h2200_0000);
    stall_en = 1'b0;

    // Error abort at source index 2
    fill(DST, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    err_addr = SRC + 32'h8;
    i0 = in_log.size();
    start_job(SRC, DST, 16'd4);
    wait_done(200, lat);
    chk("err_latency", lat, 32'd10);
    chk("err_flag", {31'h0, err}, 32'h1);
    chk("err_in_cnt", in_log.size() - i0, 32'd2);
    g0 = n_gnt;
    repeat (5) @(negedge clk_i);
    chk("err_no_more_req", n_gnt - g0, 32'd0);
    chk("err_sticky", {31'h0, err}, 32'h1);
    chk("err_dst0", mem[DST[11:2]], 32'hA5A5_A5A5);
    chk("err_dst3", mem[DST[11:2] + 10'd3], 32'hA5A5_A5A5);
    err_addr = 32'hFFFF_FFFF;
    start_job(SRC, DST, 16'd0);
    chk("err_cleared", {31'h0, err}, 32'h0);
    @(negedge clk_i);

    // Reset during DST_WR of word 1, then a fresh job
    fill(SRC, 32'h0000_0001, 32'h8000_0000, 32'h0000_00F0, 32'h1234_5678);
    fill(DST, 32'h0, 32'h0, 32'h0, 32'h0);
    start_job(SRC, DST, 16'd4);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      if (req_s.req && req_s.a.we && req_s.a.addr == DST + 32'h4) begin
        lat = k;
        break;
      end
      @(negedge clk_i);
    end
    chk("rst_mid_found", {31'h0, lat != -1}, 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_outs", {28'h0, busy, done, err, req_s.req}, 32'h0);
    chk("rst_mid_addr", req_s.a.addr, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    fill(DST, 32'h0, 32'h0, 32'h0, 32'h0);
    start_job(SRC, DST, 16'd4);
    wait_done(200, lat);
`ifndef BITREV_DMA_STATUS_POLL_EN
    chk("after_rst_latency", lat, 32'd30);
`endif
    chk("after_rst_dst0", mem[DST[11:2]], 32'h8000_0000);
    chk("after_rst_dst1", mem[DST[11:2] + 10'd1], 32'h0000_0001);
    chk("after_rst_dst2", mem[DST[11:2] + 10'd2], 32'h0F00_0000);
    chk("after_rst_dst3", mem[DST[11:2] + 10'd3], 32'h1E6A_2C48);

    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
